// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 8-bit core.
// Fetches instruction bytes over a req/ack port, drives the register file
// ports and runs a single-cycle ALU on read1/read2.
// Optional feature macro: CPU_SEQ_MUL_EN (opcode E = MUL). When it is undefined,
// opcode E behaves as a NOP.
module cpu_sequencer #(
  parameter int          DATA_WIDTH        = 8,
  parameter int          REGISTER_ID_WIDTH = 2,
  parameter int          ADDR_WIDTH        = 8,
  parameter int unsigned RESET_PC          = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         mem_rd_req,
  input  logic                         mem_rd_ack,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic [REGISTER_ID_WIDTH-1:0] rf_reg1,
  output logic [REGISTER_ID_WIDTH-1:0] rf_reg2,
  input  logic [DATA_WIDTH-1:0]        rf_read1,
  input  logic [DATA_WIDTH-1:0]        rf_read2,
  output logic [REGISTER_ID_WIDTH-1:0] rf_w_reg,
  output logic [DATA_WIDTH-1:0]        rf_w_data,
  output logic                         rf_w_en,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic                         flag_z,
  output logic                         flag_c,
  output logic                         halted
);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_FETCH_IMM, S_EXEC, S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LDI,
    OP_JMP, OP_JZ, OP_JC, OP_INC, OP_SHL, OP_SHR, OP_RSV, OP_HALT
  } opcode_t;

`ifdef CPU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   ir, imm;
  opcode_t                 opcode;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [DATA_WIDTH:0]     sum;
  logic                    alu_c, alu_z, alu_wr, alu_fw, jump_taken;
`ifdef CPU_SEQ_MUL_EN
  logic [2*DATA_WIDTH-1:0] prod;
`endif

  assign opcode = opcode_t'(ir[DATA_WIDTH-1:DATA_WIDTH-4]);

  // Register-side outputs: field extracts of ir, strobes decoded from state only.
  assign mem_addr   = pc;
  assign mem_rd_req = (state == S_FETCH) || (state == S_FETCH_IMM);
  assign halted     = (state == S_HALTED);
  assign rf_w_en    = (state == S_EXEC) && alu_wr;
  assign rf_w_data  = alu_res;
  assign rf_reg1    = ir[2*REGISTER_ID_WIDTH-1:REGISTER_ID_WIDTH];
  assign rf_reg2    = ir[REGISTER_ID_WIDTH-1:0];
  assign rf_w_reg   = ir[2*REGISTER_ID_WIDTH-1:REGISTER_ID_WIDTH];
  assign alu_z      = (alu_res == '0);

  // State register, program counter, instruction/immediate bytes and flags.
  // NOTE: every register here uses <= so all updates see pre-edge values,
  // regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_START;
      pc     <= PC_RESET;
      ir     <= '0;
      imm    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && mem_rd_ack) begin
        ir <= mem_rd_data;
        pc <= pc + ADDR_WIDTH'(1);
      end
      if (state == S_FETCH_IMM && mem_rd_ack) begin
        imm <= mem_rd_data;
        pc  <= pc + ADDR_WIDTH'(1);
      end
      if (state == S_EXEC) begin
        if (alu_fw) begin
          flag_z <= alu_z;
          flag_c <= alu_c;
        end
        if (jump_taken) pc <= ADDR_WIDTH'(imm);
      end
    end
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_START:     state_next = S_FETCH;
      S_FETCH:     if (mem_rd_ack) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP:                         state_next = S_FETCH;
          OP_RSV:                         state_next = MUL_EN ? S_EXEC : S_FETCH;
          OP_HALT:                        state_next = S_HALTED;
          OP_LDI, OP_JMP, OP_JZ, OP_JC:   state_next = S_FETCH_IMM;
          default:                        state_next = S_EXEC;
        endcase
      end
      S_FETCH_IMM: if (mem_rd_ack) state_next = S_EXEC;
      S_EXEC:      state_next = S_FETCH;
      S_HALTED:    state_next = S_HALTED;
      default:     state_next = S_START;
    endcase
  end

  // ALU result, carry, register-write/flag-write decode and branch decision.
  always_comb begin
    alu_res    = rf_read1;
    alu_c      = flag_c;
    alu_wr     = 1'b0;
    alu_fw     = 1'b0;
    jump_taken = 1'b0;
    sum        = '0;
`ifdef CPU_SEQ_MUL_EN
    prod       = '0;
`endif
    case (opcode)
      OP_ADD: begin
        sum     = {1'b0, rf_read1} + {1'b0, rf_read2};
        alu_res = sum[DATA_WIDTH-1:0];
        alu_c   = sum[DATA_WIDTH];
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
      OP_SUB: begin
        alu_res = rf_read1 - rf_read2;
        alu_c   = (rf_read1 < rf_read2);
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
      OP_AND: begin
        alu_res = rf_read1 & rf_read2;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
      OP_OR: begin
        alu_res = rf_read1 | rf_read2;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
      OP_XOR: begin
        alu_res = rf_read1 ^ rf_read2;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
      OP_MOV: begin
        alu_res = rf_read2;
        alu_wr  = 1'b1;
      end
      OP_LDI: begin
        alu_res = imm;
        alu_wr  = 1'b1;
      end
      OP_JMP: jump_taken = 1'b1;
      OP_JZ:  jump_taken = flag_z;
      OP_JC:  jump_taken = flag_c;
      OP_INC: begin
        alu_res = rf_read1 + DATA_WIDTH'(1);
        alu_c   = (rf_read1 == '1);
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
      OP_SHL: begin
        alu_res = {rf_read1[DATA_WIDTH-2:0], 1'b0};
        alu_c   = rf_read1[DATA_WIDTH-1];
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, rf_read1[DATA_WIDTH-1:1]};
        alu_c   = rf_read1[0];
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
`ifdef CPU_SEQ_MUL_EN
      OP_RSV: begin
        prod    = {{DATA_WIDTH{1'b0}}, rf_read1} * {{DATA_WIDTH{1'b0}}, rf_read2};
        alu_res = prod[DATA_WIDTH-1:0];
        alu_c   = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
        alu_wr  = 1'b1;
        alu_fw  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer with a behavioural
// program memory (programmable ack delay, optional stray acks) and a
// behavioural 4x8 register file.
module tb_cpu_sequencer;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_req;
  logic          mem_rd_ack;
  logic [7:0]    mem_rd_data;
  logic [1:0]    rf_reg1, rf_reg2, rf_w_reg;
  logic [7:0]    rf_read1, rf_read2, rf_w_data;
  logic          rf_w_en;
  logic [AW-1:0] pc;
  logic          flag_z, flag_c, halted;

  cpu_sequencer #(
    .DATA_WIDTH(8), .REGISTER_ID_WIDTH(2), .ADDR_WIDTH(AW), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_read1(rf_read1), .rf_read2(rf_read2),
    .rf_w_reg(rf_w_reg), .rf_w_data(rf_w_data), .rf_w_en(rf_w_en),
    .pc(pc), .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory and register-file models
  logic [7:0]      mem [256];
  logic [0:3][7:0] regs;
  logic [0:3][7:0] load_val;
  logic            load_en   = 1'b0;
  logic            stray_ack = 1'b0;
  int              ack_delay = 0;
  int              wait_cnt  = 0;
  int              wr_cnt    = 0;

  assign mem_rd_ack  = (mem_rd_req && wait_cnt >= ack_delay) || stray_ack;
  assign mem_rd_data = mem_rd_ack ? mem[mem_addr] : 8'hFF;
  assign rf_read1    = regs[rf_reg1];
  assign rf_read2    = regs[rf_reg2];

  always @(posedge clk) begin
    if (load_en) begin
      regs   <= load_val;
      wr_cnt <= 0;
    end else if (rf_w_en) begin
      regs[rf_w_reg] <= rf_w_data;
      wr_cnt         <= wr_cnt + 1;
    end
    if (!mem_rd_req || mem_rd_ack) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string           name;
    logic [0:7][7:0] prog;
    logic [7:0]      hi_byte;
    logic [0:3][7:0] init_regs;
    logic [0:3][7:0] exp_regs;
    logic            exp_z;
    logic            exp_c;
    logic [7:0]      exp_pc;
    int              exp_wr;
    int              delay;
    logic            stray;
  } vec_t;

  vec_t vecs [12];

  task automatic fill_mem(input logic [7:0] fill);
    for (int i = 0; i < 256; i++) mem[i] = fill;
  endtask

  // Reset with a preloaded register file; returns at the negedge where rst falls.
  task automatic start_dut(input logic [0:3][7:0] init, input int dly, input logic stray);
    rst       = 1'b1;
    stray_ack = 1'b0;
    ack_delay = dly;
    load_val  = init;
    load_en   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_en   = 1'b0;
    rst       = 1'b0;
    stray_ack = stray;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int busy;
    fill_mem(8'hF0);
    for (int i = 0; i < 8; i++) mem[i] = v.prog[i];
    mem[255] = v.hi_byte;
    start_dut(v.init_regs, v.delay, v.stray);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, " halted"}, {31'd0, halted}, 32'd1);
    check({v.name, " regs"},   regs,            v.exp_regs);
    check({v.name, " z"},      {31'd0, flag_z}, {31'd0, v.exp_z});
    check({v.name, " c"},      {31'd0, flag_c}, {31'd0, v.exp_c});
    check({v.name, " pc"},     {24'd0, pc},     {24'd0, v.exp_pc});
    check({v.name, " writes"}, wr_cnt,          v.exp_wr);
    busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_rd_req || rf_w_en) busy++;
    end
    check({v.name, " idle_after_halt"}, busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:7] exp_req;
    logic [1:7] exp_wen;
    int         cyc;

    vecs[0]  = '{"ldi_add",    64'h70F0_7420_11F0_F0F0, 8'hF0, 32'h0000_0000, 32'h1020_0000, 1'b0, 1'b1, 8'h06, 3, 0, 1'b0};
    vecs[1]  = '{"sub_jz",     64'h2A90_40F0_F0F0_F0F0, 8'hF0, 32'h0000_5500, 32'h0000_0000, 1'b1, 1'b0, 8'h41, 1, 1, 1'b0};
    vecs[2]  = '{"jc_not",     64'h2AA0_10F0_F0F0_F0F0, 8'hF0, 32'h0000_5500, 32'h0000_0000, 1'b1, 1'b0, 8'h04, 1, 0, 1'b0};
    vecs[3]  = '{"inc_and",    64'h70FF_B035_F0F0_F0F0, 8'hF0, 32'h000F_0000, 32'h000F_0000, 1'b0, 1'b0, 8'h05, 3, 2, 1'b0};
    vecs[4]  = '{"shl_mov_jc", 64'hCC63_A020_F0F0_F0F0, 8'hF0, 32'h0000_0080, 32'h0000_0000, 1'b1, 1'b1, 8'h21, 2, 0, 1'b0};
    vecs[5]  = '{"shr_xor_or", 64'hD459_4DF0_F0F0_F0F0, 8'hF0, 32'h0003_0180, 32'h0001_0081, 1'b0, 1'b0, 8'h04, 3, 1, 1'b0};
    vecs[6]  = '{"sub_borrow", 64'h21F0_F0F0_F0F0_F0F0, 8'hF0, 32'h1020_0000, 32'hF020_0000, 1'b0, 1'b1, 8'h02, 1, 0, 1'b0};
`ifdef CPU_SEQ_MUL_EN
    vecs[7]  = '{"op_e_mul",   64'hB0E6_F0F0_F0F0_F0F0, 8'hF0, 32'hFF10_1100, 32'h0010_1100, 1'b0, 1'b1, 8'h03, 2, 0, 1'b0};
`else
    vecs[7]  = '{"op_e_nop",   64'hB0E6_F0F0_F0F0_F0F0, 8'hF0, 32'hFF10_1100, 32'h0010_1100, 1'b1, 1'b1, 8'h03, 1, 0, 1'b0};
`endif
    vecs[8]  = '{"add_self",   64'h1FF0_F0F0_F0F0_F0F0, 8'hF0, 32'h0000_0081, 32'h0000_0002, 1'b0, 1'b1, 8'h02, 1, 3, 1'b0};
    vecs[9]  = '{"nop",        64'h70FF_B000_F0F0_F0F0, 8'hF0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 8'h05, 2, 0, 1'b0};
    vecs[10] = '{"stray_ack",  64'h70F0_7420_11F0_F0F0, 8'hF0, 32'h0000_0000, 32'h1020_0000, 1'b0, 1'b1, 8'h06, 3, 2, 1'b1};
    vecs[11] = '{"pc_wrap",    64'h81FF_F0F0_F0F0_F0F0, 8'h7C, 32'h0000_0000, 32'h0000_0081, 1'b0, 1'b0, 8'h02, 1, 1, 1'b0};

    // Reset state, first request timing and a 3-wait-cycle ADD r2,r3
    fill_mem(8'hF0);
    mem[0] = 8'h1B;
    start_dut(32'h0000_0507, 3, 1'b0);
    #1;
    check("rst req",    {31'd0, mem_rd_req}, 32'd0);
    check("rst halted", {31'd0, halted},     32'd0);
    check("rst z",      {31'd0, flag_z},     32'd0);
    check("rst c",      {31'd0, flag_c},     32'd0);
    check("rst pc",     {24'd0, pc},         32'd0);
    exp_req = 7'b1111001;
    exp_wen = 7'b0000010;
    for (cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      check($sformatf("wait c%0d req", cyc),  {31'd0, mem_rd_req}, {31'd0, exp_req[cyc]});
      check($sformatf("wait c%0d wen", cyc),  {31'd0, rf_w_en},    {31'd0, exp_wen[cyc]});
      check($sformatf("wait c%0d addr", cyc), {24'd0, mem_addr},   (cyc <= 4) ? 32'd0 : 32'd1);
      check($sformatf("wait c%0d reg1", cyc), {30'd0, rf_reg1},    (cyc <= 4) ? 32'd0 : 32'd2);
      check($sformatf("wait c%0d reg2", cyc), {30'd0, rf_reg2},    (cyc <= 4) ? 32'd0 : 32'd3);
      if (cyc == 6) check("wait add data", {24'd0, rf_w_data}, 32'h0C);
    end
    check("wait add r2", {24'd0, regs[2]}, 32'h0C);

    // Table-driven programs
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset asserted mid-fetch: ADD r0,r0 everywhere, slow acks
    fill_mem(8'h10);
    start_dut(32'h0100_0000, 4, 1'b0);
    cyc = 0;
    while (!(mem_rd_req && pc == 8'd2) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst reached fetch", {31'd0, mem_rd_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst req",  {31'd0, mem_rd_req}, 32'd0);
    check("midrst pc",   {24'd0, pc},         32'd0);
    check("midrst wen",  {31'd0, rf_w_en},    32'd0);
    repeat (3) @(negedge clk);
    check("midrst writes", wr_cnt,          32'd2);
    check("midrst r0",     {24'd0, regs[0]}, 32'h04);
    rst = 1'b0;
    @(negedge clk);
    check("midrst refetch req",  {31'd0, mem_rd_req}, 32'd1);
    check("midrst refetch addr", {24'd0, mem_addr},   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
